// File: rtl/schematic_16bit_rf_pkg.sv
// Shared widths and word type for the 16-bit register file.
package schematic_16bit_rf_pkg;
   localparam int DATA_W   = 16;
   localparam int ADDR_W   = 3;
   localparam int NUM_REGS = 2**ADDR_W;

   typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/schematic_16bit_rf_read_port.sv
// One combinational read port: address mux plus optional write-to-read forwarding.
// Forwarding is compiled in with `define RF_BYPASS_EN.
module rf_read_port
   import schematic_16bit_rf_pkg::*;
#(
   parameter int DATA_W = schematic_16bit_rf_pkg::DATA_W,
   parameter int ADDR_W = schematic_16bit_rf_pkg::ADDR_W
) (
   input  logic [2**ADDR_W-1:0][DATA_W-1:0] regs,
   input  logic [ADDR_W-1:0]                rd_addr,
   input  logic                             byp_vld,
   input  logic [ADDR_W-1:0]                wr_addr,
   input  logic [DATA_W-1:0]                wr_data,
   output logic [DATA_W-1:0]                rd_data
);

`ifdef RF_BYPASS_EN
   // byp_vld already folds in WE and rst_n, so forwarding never leaks during reset
   always_comb begin
      rd_data = regs[rd_addr];
      if (byp_vld && (wr_addr == rd_addr))
         rd_data = wr_data;
   end
`else
   logic unused_byp;
   assign unused_byp = ^{byp_vld, wr_addr, wr_data};
   assign rd_data    = regs[rd_addr];
`endif

endmodule

// File: rtl/schematic_16bit_rf.sv
// 2**ADDR_W x DATA_W register file, one write port, two combinational read ports.
// Optional same-cycle forwarding is enabled with `define RF_BYPASS_EN.
module schematic_16bit_rf
   import schematic_16bit_rf_pkg::*;
#(
   parameter int DATA_W = schematic_16bit_rf_pkg::DATA_W,
   parameter int ADDR_W = schematic_16bit_rf_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              WE,
   input  logic [ADDR_W-1:0] WR_addr,
   input  logic [DATA_W-1:0] WR_data,
   input  logic [ADDR_W-1:0] RA_addr,
   input  logic [ADDR_W-1:0] RB_addr,
   output logic [DATA_W-1:0] RA_data,
   output logic [DATA_W-1:0] RB_data
);

   logic [2**ADDR_W-1:0][DATA_W-1:0] regs;
   logic                             byp_vld;

   // reset wins over a coincident write; register 0 is an ordinary register
   always_ff @(posedge clk) begin
      if (!rst_n)
         regs <= '0;
      else if (WE)
         regs[WR_addr] <= WR_data;
   end

   assign byp_vld = WE & rst_n;

   rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_a (
      .regs    (regs),
      .rd_addr (RA_addr),
      .byp_vld (byp_vld),
      .wr_addr (WR_addr),
      .wr_data (WR_data),
      .rd_data (RA_data)
   );

   rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_b (
      .regs    (regs),
      .rd_addr (RB_addr),
      .byp_vld (byp_vld),
      .wr_addr (WR_addr),
      .wr_data (WR_data),
      .rd_data (RB_data)
   );

endmodule

// File: tb/tb_schematic_16bit_rf.sv
// Directed bench for schematic_16bit_rf with an expected-value queue and a shadow register model.
module tb_schematic_16bit_rf;
   import schematic_16bit_rf_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        WE;
   logic [2:0]  WR_addr;
   logic [15:0] WR_data;
   logic [2:0]  RA_addr;
   logic [2:0]  RB_addr;
   logic [15:0] RA_data;
   logic [15:0] RB_data;

   int    vectors = 0;
   int    errors  = 0;
   word_t exp_q[$];
   word_t model[NUM_REGS];

   schematic_16bit_rf dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .WE      (WE),
      .WR_addr (WR_addr),
      .WR_data (WR_data),
      .RA_addr (RA_addr),
      .RB_addr (RB_addr),
      .RA_data (RA_data),
      .RB_data (RB_data)
   );

   always #5 clk = ~clk;

   // inputs change just after the falling edge, so every rising edge sees stable values
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic cmp(input string tag, input word_t obs);
      word_t exp_v;
      exp_v = exp_q.pop_front();
      vectors++;
      assert (obs === exp_v)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   task automatic rd(input string tag, input logic [2:0] a, input logic [2:0] b,
                     input word_t ea, input word_t eb);
      RA_addr = a;
      RB_addr = b;
      exp_q.push_back(ea);
      exp_q.push_back(eb);
      #2;
      cmp({tag, "_A"}, RA_data);
      cmp({tag, "_B"}, RB_data);
   endtask

   task automatic wr(input logic [2:0] a, input word_t d);
      WE      = 1'b1;
      WR_addr = a;
      WR_data = d;
      tick();
      WE      = 1'b0;
   endtask

   initial begin
      rst_n   = 1'b0;
      WE      = 1'b0;
      WR_addr = '0;
      WR_data = '0;
      RA_addr = '0;
      RB_addr = '0;
      @(negedge clk);
      tick();
      rst_n = 1'b1;

      // reset state on every address, both ports
      for (int i = 0; i < 8; i++)
         rd("reset", 3'(i), 3'(7 - i), 16'h0000, 16'h0000);

      // overwrite: last write wins
      wr(3'd6, 16'hABCD);
      wr(3'd6, 16'h1234);
      rd("overwrite", 3'd6, 3'd6, 16'h1234, 16'h1234);
      rd("untouched", 3'd1, 3'd2, 16'h0000, 16'h0000);

      // independent dual read, then swapped
      rd("dual", 3'd3, 3'd6, 16'h0000, 16'h1234);
      rd("dual_swap", 3'd6, 3'd3, 16'h1234, 16'h0000);

      // WE=0 ignores address and data
      WE      = 1'b0;
      WR_addr = 3'd2;
      WR_data = 16'hFFFF;
      tick();
      rd("we_off", 3'd2, 3'd2, 16'h0000, 16'h0000);

      // same-cycle read of the address being written
      wr(3'd5, 16'h0001);
      WE      = 1'b1;
      WR_addr = 3'd5;
      WR_data = 16'h5A5A;
`ifdef RF_BYPASS_EN
      rd("rw_same_pre", 3'd5, 3'd6, 16'h5A5A, 16'h1234);
`else
      rd("rw_same_pre", 3'd5, 3'd6, 16'h0001, 16'h1234);
`endif
      tick();
      WE = 1'b0;
      rd("rw_same_post", 3'd5, 3'd5, 16'h5A5A, 16'h5A5A);

      // reset beats a simultaneous write; forwarding stays off while in reset
      rst_n   = 1'b0;
      WE      = 1'b1;
      WR_addr = 3'd4;
      WR_data = 16'hBEEF;
      rd("rst_pend", 3'd4, 3'd6, 16'h0000, 16'h1234);
      tick();
      rd("rst_prio", 3'd4, 3'd6, 16'h0000, 16'h0000);
      rd("rst_clr", 3'd5, 3'd5, 16'h0000, 16'h0000);

      // first edge after deassert takes a write, including to address 0
      rst_n   = 1'b1;
      WE      = 1'b1;
      WR_addr = 3'd0;
      WR_data = 16'hC0DE;
      tick();
      WE = 1'b0;
      rd("post_rst_wr", 3'd0, 3'd1, 16'hC0DE, 16'h0000);

      // random traffic against a shadow model
      for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
      model[0] = 16'hC0DE;
      for (int n = 0; n < 40; n++) begin
         logic [2:0] wa, a, b;
         word_t      wd;
         wa = 3'($urandom_range(0, 7));
         wd = 16'($urandom);
         a  = 3'($urandom_range(0, 7));
         b  = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 3) != 0) begin
            wr(wa, wd);
            model[wa] = wd;
         end else begin
            WE = 1'b0; WR_addr = wa; WR_data = wd;
            tick();
         end
         rd("random", a, b, model[a], model[b]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
